// File: rtl/toags_window.sv
// Sliding-window bitwise AND over the last DEPTH accepted W-bit samples (IDLE -> FILL -> RUN).
// Define TOAGS_OR_EN to add __out2, the bitwise OR of the same window.
module toags_window #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] __in0,
    input  logic         __in1,
    input  logic         __in2,
    output logic [W-1:0] __out0,
    output logic         __out1
`ifdef TOAGS_OR_EN
    ,
    output logic [W-1:0] __out2
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } tag_t;

    logic [W-1:0]  win_q [DEPTH];
    logic [W-1:0]  win_d [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    tag_t          tag_q, tag_d;
    logic [W-1:0]  out0_q, out0_d;
    logic          out1_q, out1_d;
    logic [CW-1:0] cnt_inc;
    logic          full;
    logic [W-1:0]  and_v;
`ifdef TOAGS_OR_EN
    logic [W-1:0]  out2_q, out2_d;
    logic [W-1:0]  or_v;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            cnt_q  <= '0;
            tag_q  <= IDLE;
            out0_q <= '0;
            out1_q <= 1'b0;
`ifdef TOAGS_OR_EN
            out2_q <= '0;
`endif
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= win_d[i];
            end
            cnt_q  <= cnt_d;
            tag_q  <= tag_d;
            out0_q <= out0_d;
            out1_q <= out1_d;
`ifdef TOAGS_OR_EN
            out2_q <= out2_d;
`endif
        end
    end

    always_comb begin
        // Reduction runs over the post-shift window: new sample plus the DEPTH-1 youngest old entries.
        and_v = __in0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            and_v = and_v & win_q[i];
        end
`ifdef TOAGS_OR_EN
        or_v = __in0;
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            or_v = or_v | win_q[i];
        end
`endif
        cnt_inc = (cnt_q >= CW'(DEPTH)) ? CW'(DEPTH) : cnt_q + 1'b1;
        full    = (cnt_inc == CW'(DEPTH));
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            win_d[i] = win_q[i];
        end
        cnt_d  = cnt_q;
        tag_d  = tag_q;
        out0_d = out0_q;
        out1_d = 1'b0;
`ifdef TOAGS_OR_EN
        out2_d = out2_q;
`endif
        if (__in2) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_d[i] = '0;
            end
            cnt_d  = '0;
            tag_d  = IDLE;
            out0_d = '0;
`ifdef TOAGS_OR_EN
            out2_d = '0;
`endif
        end else if (__in1) begin
            win_d[0] = __in0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                win_d[i] = win_q[i-1];
            end
            cnt_d  = cnt_inc;
            tag_d  = full ? RUN : FILL;
            out0_d = full ? and_v : '0;
            out1_d = full;
`ifdef TOAGS_OR_EN
            out2_d = full ? or_v : '0;
`endif
        end else begin
            case (tag_q)
                IDLE, FILL, RUN: tag_d = tag_q;
                default:         tag_d = IDLE;
            endcase
        end
    end

    assign __out0 = out0_q;
    assign __out1 = out1_q;
`ifdef TOAGS_OR_EN
    assign __out2 = out2_q;
`endif

endmodule

// File: tb/tb_toags_window.sv
// Directed self-checking bench for toags_window: W=4/DEPTH=3 and W=1/DEPTH=2 instances.
// Build with TOAGS_OR_EN defined to also exercise the OR output.
module tb_toags_window;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic [3:0] a_in0 = '0;
    logic       a_in1 = 1'b0, a_in2 = 1'b0;
    logic [3:0] a_out0;
    logic       a_out1;
    logic [0:0] b_in0 = '0;
    logic       b_in1 = 1'b0, b_in2 = 1'b0;
    logic [0:0] b_out0;
    logic       b_out1;
`ifdef TOAGS_OR_EN
    logic [3:0] a_out2;
    logic [0:0] b_out2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    toags_window #(.W(4), .DEPTH(3)) dut_a (
        .clk    (clk),
        .rst    (rst_a),
        .__in0  (a_in0),
        .__in1  (a_in1),
        .__in2  (a_in2),
        .__out0 (a_out0),
        .__out1 (a_out1)
`ifdef TOAGS_OR_EN
        ,
        .__out2 (a_out2)
`endif
    );

    toags_window #(.W(1), .DEPTH(2)) dut_b (
        .clk    (clk),
        .rst    (rst_b),
        .__in0  (b_in0),
        .__in1  (b_in1),
        .__in2  (b_in2),
        .__out0 (b_out0),
        .__out1 (b_out1)
`ifdef TOAGS_OR_EN
        ,
        .__out2 (b_out2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step_a(input logic [3:0] d, input logic v, input logic c);
        @(negedge clk);
        a_in0 = d;
        a_in1 = v;
        a_in2 = c;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic d, input logic v);
        @(negedge clk);
        b_in0 = d;
        b_in1 = v;
        b_in2 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: reset, then fill with F, E, 7
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out0", a_out0, 4'h0);
        check("rst_out1", a_out1, 1'b0);
        check("rst_cnt", dut_a.cnt_q, 2'd0);
        check("rst_tag", dut_a.tag_q, 2'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        step_a(4'hF, 1'b1, 1'b0);
        check("t1_e1_out1", a_out1, 1'b0);
        check("t1_e1_tag", dut_a.tag_q, 2'd1);
        step_a(4'hE, 1'b1, 1'b0);
        check("t1_e2_out1", a_out1, 1'b0);
        check("t1_e2_tag", dut_a.tag_q, 2'd1);
        step_a(4'h7, 1'b1, 1'b0);
        check("t1_e3_out1", a_out1, 1'b1);
        check("t1_e3_out0", a_out0, 4'h6);
        check("t1_e3_tag", dut_a.tag_q, 2'd2);

        // Test 2: slide in 3, then two idle cycles hold the result
        step_a(4'h3, 1'b1, 1'b0);
        check("t2_out0", a_out0, 4'h2);
        check("t2_out1", a_out1, 1'b1);
        check("t2_cnt", dut_a.cnt_q, 2'd3);
        for (int i = 0; i < 2; i++) begin
            step_a(4'h0, 1'b0, 1'b0);
            check("t2_hold_out0", a_out0, 4'h2);
            check("t2_hold_out1", a_out1, 1'b0);
        end

        // Test 3: clear wins over a simultaneous accept
        step_a(4'hF, 1'b1, 1'b1);
        check("t3_clr_cnt", dut_a.cnt_q, 2'd0);
        check("t3_clr_tag", dut_a.tag_q, 2'd0);
        check("t3_clr_out0", a_out0, 4'h0);
        check("t3_clr_out1", a_out1, 1'b0);
        step_a(4'hF, 1'b1, 1'b0);
        check("t3_a1_out1", a_out1, 1'b0);
        step_a(4'hF, 1'b1, 1'b0);
        check("t3_a2_out1", a_out1, 1'b0);
        step_a(4'hF, 1'b1, 1'b0);
        check("t3_a3_out1", a_out1, 1'b1);
        check("t3_a3_out0", a_out0, 4'hF);

        // Test 4a: asynchronous reset in RUN clears a live result without a clock edge
        step_a(4'h0, 1'b0, 1'b0);
        check("t4_pre_out0", a_out0, 4'hF);
        #1 rst_a = 1'b1;
        #1;
        check("t4a_async_out0", a_out0, 4'h0);
        check("t4a_async_cnt", dut_a.cnt_q, 2'd0);
        #1 rst_a = 1'b0;

        // Test 4b: asynchronous reset during FILL with cnt=2
        step_a(4'h9, 1'b1, 1'b0);
        step_a(4'hB, 1'b1, 1'b0);
        check("t4b_pre_cnt", dut_a.cnt_q, 2'd2);
        a_in1 = 1'b0;
        #1 rst_a = 1'b1;
        #1;
        check("t4b_async_cnt", dut_a.cnt_q, 2'd0);
        check("t4b_async_tag", dut_a.tag_q, 2'd0);
        check("t4b_async_out1", a_out1, 1'b0);
        #1 rst_a = 1'b0;
        step_a(4'hD, 1'b1, 1'b0);
        check("t4b_r1_out1", a_out1, 1'b0);
        step_a(4'h5, 1'b1, 1'b0);
        check("t4b_r2_out1", a_out1, 1'b0);
        step_a(4'h7, 1'b1, 1'b0);
        check("t4b_r3_out1", a_out1, 1'b1);
        check("t4b_r3_out0", a_out0, 4'h5);

        // Test 5: DEPTH=2, W=1 saturation
        step_b(1'b1, 1'b1);
        check("t5_s1_out1", b_out1, 1'b0);
        step_b(1'b1, 1'b1);
        check("t5_s2_out1", b_out1, 1'b1);
        check("t5_s2_out0", b_out0, 1'b1);
        step_b(1'b1, 1'b1);
        check("t5_s3_out1", b_out1, 1'b1);
        check("t5_s3_out0", b_out0, 1'b1);
        check("t5_s3_cnt", dut_b.cnt_q, 2'd2);
        step_b(1'b0, 1'b1);
        check("t5_s4_out1", b_out1, 1'b1);
        check("t5_s4_out0", b_out0, 1'b0);
        step_b(1'b1, 1'b1);
        check("t5_s5_out1", b_out1, 1'b1);
        check("t5_s5_out0", b_out0, 1'b0);
        check("t5_s5_cnt", dut_b.cnt_q, 2'd2);

`ifdef TOAGS_OR_EN
        // Test 6: OR output alongside AND
        step_a(4'h0, 1'b0, 1'b1);
        step_a(4'h1, 1'b1, 1'b0);
        check("t6_a1_out2", a_out2, 4'h0);
        step_a(4'h2, 1'b1, 1'b0);
        step_a(4'h4, 1'b1, 1'b0);
        check("t6_out0", a_out0, 4'h0);
        check("t6_out2", a_out2, 4'h7);
        check("t6_out1", a_out1, 1'b1);
        step_a(4'h0, 1'b0, 1'b0);
        check("t6_hold_out2", a_out2, 4'h7);
        step_a(4'h0, 1'b0, 1'b1);
        check("t6_clr_out2", a_out2, 4'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
